// File: rtl/lpc_pkg.sv
// Shared types and widths for the LPC coefficient path.
package lpc_pkg;
  localparam int COEFF_W       = 12;
  localparam int ORDER_W       = 4;
  localparam int ERR_W         = 32;
  localparam int MAX_LPC_ORDER = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SELECT = 3'd2,
    ST_UNLOAD = 3'd3,
    ST_FINISH = 3'd4
  } state_t;
endpackage

// File: rtl/order_cost_cmp.sv
// Penalised model cost with saturation, and strict-less comparison against the current best.
// Purely combinational.
module order_cost_cmp
  import lpc_pkg::*;
#(
  parameter logic [ERR_W-1:0] ORDER_PENALTY = '0
) (
  input  logic [ERR_W-1:0]   err_i,
  input  logic [ORDER_W-1:0] m_i,
  input  logic [ERR_W-1:0]   best_cost_i,
  output logic [ERR_W-1:0]   cost_o,
  output logic               better_o
);
  logic [ERR_W+3:0] sum;

  always_comb begin
    // 36 bits cannot overflow: worst case is 16 * (2^32 - 1).
    sum      = {4'b0, err_i} + ({4'b0, ORDER_PENALTY} * {{ERR_W{1'b0}}, m_i});
    cost_o   = (sum[ERR_W+3:ERR_W] != 4'b0) ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
    better_o = (cost_o < best_cost_i);
  end
endmodule

// File: rtl/durbin_order_scheduler.sv
// Loads Durbin coefficients into the store, picks the cheapest model order, then unloads it.
// All outputs registered; load and unload paths have one cycle of latency.
module durbin_order_scheduler
  import lpc_pkg::*;
#(
  parameter int               MAX_ORDER     = MAX_LPC_ORDER,
  parameter logic [ERR_W-1:0] ORDER_PENALTY = 32'd0
) (
  input  logic                 iClock,
  input  logic                 iReset_n,
  input  logic                 iEnable,
  input  logic                 iStart,
  input  logic                 iCoeffValid,
  input  logic [ORDER_W-1:0]   iM,
  input  logic [COEFF_W-1:0]   iCoeff,
  input  logic                 iOrderDone,
  input  logic [ERR_W-1:0]     iError,
  output logic                 oLoad,
  output logic [ORDER_W-1:0]   oM,
  output logic [COEFF_W-1:0]   oStoreCoeff,
  output logic                 oUnload,
  output logic [ORDER_W-1:0]   oBestM,
  input  logic [COEFF_W-1:0]   iStoreCoeff,
  input  logic                 iStoreValid,
  input  logic                 iStoreDone,
  output logic [COEFF_W-1:0]   oCoeff,
  output logic                 oValid,
  output logic                 oDone,
  output logic                 oBusy,
  output logic                 oOrderErr
);
  localparam logic [ORDER_W-1:0] LAST_M = ORDER_W'(MAX_ORDER);

  state_t               state_q, state_d;
  logic [ERR_W-1:0]     best_cost_q, best_cost_d;
  logic [ORDER_W-1:0]   best_m_q, best_m_d;
  logic                 load_q, load_d;
  logic [ORDER_W-1:0]   m_q, m_d;
  logic [COEFF_W-1:0]   scoef_q, scoef_d;
  logic                 unload_q, unload_d;
  logic [ORDER_W-1:0]   bestm_q, bestm_d;
  logic [COEFF_W-1:0]   coeff_q, coeff_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;

  logic                 m_ok;
  logic [ERR_W-1:0]     cost;
  logic                 better;

  order_cost_cmp #(.ORDER_PENALTY(ORDER_PENALTY)) u_cmp (
    .err_i       (iError),
    .m_i         (iM),
    .best_cost_i (best_cost_q),
    .cost_o      (cost),
    .better_o    (better)
  );

  assign m_ok = (iM != '0) && (iM <= LAST_M);

  always_comb begin
    state_d     = state_q;
    best_cost_d = best_cost_q;
    best_m_d    = best_m_q;
    load_d      = 1'b0;
    m_d         = m_q;
    scoef_d     = scoef_q;
    unload_d    = 1'b0;
    bestm_d     = bestm_q;
    coeff_d     = coeff_q;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    busy_d      = busy_q;
    err_d       = err_q;
    if (iEnable) begin
      busy_d = (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          best_cost_d = '1;
          best_m_d    = ORDER_W'(1);
          if (iStart) begin
            err_d   = 1'b0;
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (iCoeffValid) begin
            if (m_ok) begin
              load_d  = 1'b1;
              m_d     = iM;
              scoef_d = iCoeff;
            end else begin
              err_d = 1'b1;
            end
          end
          if (iOrderDone) begin
            if (m_ok) begin
              // Strict less-than: on a tie the earlier (lower) order wins.
              if (better) begin
                best_cost_d = cost;
                best_m_d    = iM;
              end
              if (iM == LAST_M) state_d = ST_SELECT;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_SELECT: begin
          bestm_d = best_m_q;
          state_d = ST_UNLOAD;
        end
        ST_UNLOAD: begin
          if (iStoreValid) begin
            valid_d = 1'b1;
            coeff_d = iStoreCoeff;
          end
          if (iStoreDone) state_d = ST_FINISH;
        end
        ST_FINISH: begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
      // Looking at the next state lets iStoreDone drop oUnload on the same edge.
      unload_d = (state_d == ST_UNLOAD);
    end
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q     <= ST_IDLE;
      best_cost_q <= '1;
      best_m_q    <= ORDER_W'(1);
      load_q      <= 1'b0;
      m_q         <= '0;
      scoef_q     <= '0;
      unload_q    <= 1'b0;
      bestm_q     <= ORDER_W'(1);
      coeff_q     <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      best_cost_q <= best_cost_d;
      best_m_q    <= best_m_d;
      load_q      <= load_d;
      m_q         <= m_d;
      scoef_q     <= scoef_d;
      unload_q    <= unload_d;
      bestm_q     <= bestm_d;
      coeff_q     <= coeff_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign oLoad       = load_q;
  assign oM          = m_q;
  assign oStoreCoeff = scoef_q;
  assign oUnload     = unload_q;
  assign oBestM      = bestm_q;
  assign oCoeff      = coeff_q;
  assign oValid      = valid_q;
  assign oDone       = done_q;
  assign oBusy       = busy_q;
  assign oOrderErr   = err_q;
endmodule

// File: tb/tb_durbin_order_scheduler.sv
// Scoreboard bench: stimulus pushes expected load/unload beats, a negedge monitor pops and compares.
module tb_durbin_order_scheduler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        start = 1'b0;
  logic        cv = 1'b0;
  logic [3:0]  m = '0;
  logic [11:0] coeff = '0;
  logic        od = 1'b0;
  logic [31:0] err = '0;
  logic [11:0] scoeff = '0;
  logic        sv = 1'b0;
  logic        sd = 1'b0;
  logic        oLoad, oUnload, oValid, oDone, oBusy, oOrderErr;
  logic [3:0]  oM, oBestM;
  logic [11:0] oStoreCoeff, oCoeff;

  int n_cmp = 0;
  int n_err = 0;
  int done_seen = 0;
  int done_exp = 0;
  logic [15:0] load_q[$];
  logic [15:0] val_q[$];

  durbin_order_scheduler #(.MAX_ORDER(3), .ORDER_PENALTY(32'd100)) dut (
    .iClock(clk), .iReset_n(rst_n), .iEnable(en), .iStart(start),
    .iCoeffValid(cv), .iM(m), .iCoeff(coeff), .iOrderDone(od), .iError(err),
    .oLoad(oLoad), .oM(oM), .oStoreCoeff(oStoreCoeff),
    .oUnload(oUnload), .oBestM(oBestM),
    .iStoreCoeff(scoeff), .iStoreValid(sv), .iStoreDone(sd),
    .oCoeff(oCoeff), .oValid(oValid), .oDone(oDone), .oBusy(oBusy), .oOrderErr(oOrderErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (oLoad) begin
      if (load_q.size() == 0) chk("spurious_load", 64'(oLoad), 64'd0);
      else chk("load_beat", 64'({oM, oStoreCoeff}), 64'(load_q.pop_front()));
    end
    if (oValid) begin
      if (val_q.size() == 0) chk("spurious_valid", 64'(oValid), 64'd0);
      else chk("unload_beat", 64'({oBestM, oCoeff}), 64'(val_q.pop_front()));
    end
    if (oDone) done_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_coeff(input logic [3:0] mm, input logic [11:0] c, input bit expect_load);
    cv = 1'b1;
    m = mm;
    coeff = c;
    if (expect_load) load_q.push_back({mm, c});
  endtask

  task automatic run_frame(input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3,
                           input logic [3:0] bm, input logic [11:0] cbase, input bit bad, input bit stall);
    logic [31:0] ev [3];
    logic [11:0] c;
    ev[0] = e1; ev[1] = e2; ev[2] = e3;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_cleared_on_start", 64'(oOrderErr), 64'd0);
    if (bad) begin
      drive_coeff(4'd0, 12'h111, 1'b0); tick();
      drive_coeff(4'd13, 12'h222, 1'b0); tick();
      drive_coeff(4'd4, 12'h333, 1'b0); od = 1'b1; err = 32'd1; tick();
      cv = 1'b0; od = 1'b0;
      chk("order_err_set", 64'(oOrderErr), 64'd1);
      chk("order_err_busy", 64'(oBusy), 64'd1);
    end
    for (int k = 1; k <= 3; k++) begin
      c = cbase + 12'(2 * k);
      drive_coeff(4'(k), c, 1'b1);
      tick();
      drive_coeff(4'(k), c + 12'd1, 1'b1);
      od = 1'b1;
      err = ev[k-1];
      tick();
      cv = 1'b0;
      od = 1'b0;
    end
    @(negedge clk);
    chk("no_unload_in_select", 64'(oUnload), 64'd0);
    tick();
    chk("unload_at_t2", 64'(oUnload), 64'd1);
    chk("best_order", 64'(oBestM), 64'(bm));
    if (stall) begin
      en = 1'b0;
      sv = 1'b1;
      scoeff = 12'hBAD;
      tick(); tick(); tick();
      chk("stall_unload_low", 64'(oUnload), 64'd0);
      chk("stall_bestm_held", 64'(oBestM), 64'(bm));
      chk("stall_busy_held", 64'(oBusy), 64'd1);
      en = 1'b1;
      sv = 1'b0;
      tick();
      chk("unload_resumes", 64'(oUnload), 64'd1);
    end
    for (int j = 0; j < 2; j++) begin
      sv = 1'b1;
      scoeff = cbase + 12'(100 + j);
      val_q.push_back({bm, scoeff});
      sd = (j == 1);
      tick();
    end
    sv = 1'b0;
    sd = 1'b0;
    done_exp++;
    chk("unload_drops", 64'(oUnload), 64'd0);
    chk("done_not_early", 64'(oDone), 64'd0);
    tick();
    chk("done_pulse", 64'(oDone), 64'd1);
    chk("busy_in_finish", 64'(oBusy), 64'd1);
    tick();
    chk("done_one_cycle", 64'(oDone), 64'd0);
    chk("busy_falls", 64'(oBusy), 64'd0);
    if (bad) chk("order_err_sticky", 64'(oOrderErr), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_busy", 64'(oBusy), 64'd0);
    chk("rst_bestm", 64'(oBestM), 64'd1);
    chk("rst_outputs", 64'({oLoad, oUnload, oValid, oDone, oOrderErr}), 64'd0);
    rst_n = 1'b1;
    tick();
    // costs 1000, 600, 800
    run_frame(32'd900, 32'd400, 32'd500, 4'd2, 12'h010, 1'b0, 1'b0);
    // costs 400, 400, 400: tie keeps order 1
    run_frame(32'd300, 32'd200, 32'd100, 4'd1, 12'h800, 1'b0, 1'b1);
    // costs 1100, 900, 400
    run_frame(32'd1000, 32'd700, 32'd100, 4'd3, 12'hF00, 1'b0, 1'b0);
    // costs 600, saturated, 1000; plus out-of-range orders
    run_frame(32'd500, 32'hFFFFFFF0, 32'd700, 4'd1, 12'h400, 1'b1, 1'b0);
    // costs 900, 500, 450
    run_frame(32'd800, 32'd300, 32'd150, 4'd3, 12'h7F0, 1'b0, 1'b0);

    start = 1'b1;
    tick();
    start = 1'b0;
    drive_coeff(4'd1, 12'h5A5, 1'b1);
    tick();
    drive_coeff(4'd0, 12'h0AA, 1'b0);
    tick();
    cv = 1'b0;
    chk("pre_reset_err", 64'(oOrderErr), 64'd1);
    chk("pre_reset_busy", 64'(oBusy), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 64'(oBusy), 64'd0);
    chk("async_rst_err", 64'(oOrderErr), 64'd0);
    chk("async_rst_bestm", 64'(oBestM), 64'd1);
    chk("async_rst_outs", 64'({oLoad, oUnload, oValid, oDone, oM, oStoreCoeff, oCoeff}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 64'(oBusy), 64'd0);
    run_frame(32'd900, 32'd400, 32'd500, 4'd2, 12'h020, 1'b0, 1'b0);

    tick(); tick();
    chk("load_queue_drained", 64'(load_q.size()), 64'd0);
    chk("unload_queue_drained", 64'(val_q.size()), 64'd0);
    chk("done_count", 64'(done_seen), 64'(done_exp));
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
